// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
//
// Shares the CPU's single memory bus between the instruction-fetch port (i_*)
// and the load/store data port (d_*). One transaction is granted at a time.
// Simultaneous requests from IDLE are resolved round-robin against the last
// granted port. A grant is held until the slave drops waitrequest, and a
// sticky bus_error flags any transaction that stalls for WAIT_LIMIT cycles.
//
// Parameters
//   WAIT_LIMIT   consecutive wait-state cycles in one transaction that set
//                bus_error (minimum 1)
//
// Ports
//   clk             sole clock, all state updates on posedge
//   rst             synchronous, active-low reset
//   i_address       instruction-fetch address
//   i_read          instruction-fetch read request
//   i_waitrequest   stall to the fetch port
//   i_readdata      fetch read data (valid in the fetch completion cycle)
//   d_address       data-port address
//   d_read          data read request
//   d_write         data write request
//   d_writedata     store data
//   d_byteenable    store/load byte lanes
//   d_waitrequest   stall to the data port
//   d_readdata      load data (valid in the data completion cycle)
//   address         memory bus address
//   read            memory read strobe
//   write           memory write strobe
//   writedata       memory write data
//   byteenable      memory byte lanes
//   waitrequest     memory stall
//   readdata        memory read data
//   grant           current owner: 00 none, 01 instr, 10 data
//   bus_error       sticky wait-limit violation flag
// -----------------------------------------------------------------------------
module mips_bus_arbiter #(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,

  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,

  output logic [1:0]  grant,
  output logic        bus_error
);

  // Counter must be able to hold WAIT_LIMIT itself, since it saturates there.
  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  // State encoding doubles as the grant output encoding.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_I = 2'b01;
  localparam logic [1:0] GNT_D = 2'b10;

  localparam logic LG_INSTR = 1'b0;
  localparam logic LG_DATA  = 1'b1;

  logic [1:0]       state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic             bus_error_q,  bus_error_d;

  logic i_req;
  logic d_req;
  logic pick_i;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Instr wins when it is the only requester, or on a tie when data was
  // granted last.
  assign pick_i = i_req & (~d_req | (last_grant_q == LG_DATA));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    bus_error_d  = bus_error_q;

    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d      = GNT_I;
          last_grant_d = LG_INSTR;
          wait_cnt_d   = '0;
        end else if (d_req) begin
          state_d      = GNT_D;
          last_grant_d = LG_DATA;
          wait_cnt_d   = '0;
        end
      end

      GNT_I, GNT_D: begin
        if (!waitrequest) begin
          // Completion cycle: always return to IDLE so the request the master
          // is still holding this cycle is not granted a second time.
          state_d = IDLE;
        end else if (wait_cnt_q != LIMIT) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // The grant is not aborted; the error is only recorded.
          if (wait_cnt_q == LIMIT - 1'b1) begin
            bus_error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= LG_DATA;   // instr wins the first tie after reset
      wait_cnt_q   <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: registered state plus pass-through of the owner's inputs
  // ---------------------------------------------------------------------------
  always_comb begin
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;

    case (state_q)
      GNT_I: begin
        address    = i_address;
        read       = 1'b1;
        byteenable = 4'b1111;
      end
      GNT_D: begin
        address    = d_address;
        write      = d_write;
        // A malformed read+write request is treated as a write.
        read       = d_read & ~d_write;
        writedata  = d_writedata;
        byteenable = d_byteenable;
      end
      default: ;
    endcase
  end

  assign i_waitrequest = ~((state_q == GNT_I) & ~waitrequest);
  assign d_waitrequest = ~((state_q == GNT_D) & ~waitrequest);

  // Read data is shared; each port only samples it in its own completion cycle.
  assign i_readdata = readdata;
  assign d_readdata = readdata;

  assign grant     = state_q;
  assign bus_error = bus_error_q;

endmodule
